// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver. Frames start + 8 data bits
// (LSB first) + optional parity + one stop bit, and delivers each byte with a
// one-cycle valid strobe plus parity/framing status.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       include_parity,
   input  logic       parity_type,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       parity_error,
   output logic       frame_error,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   logic          rx_meta_q, rx_s_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_en_q, par_en_d;
   logic          par_odd_q, par_odd_d;
   logic          par_bit_q, par_bit_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          data_valid_q, data_valid_d;
   logic          parity_error_q, parity_error_d;
   logic          frame_error_q, frame_error_d;
   logic          busy_q, busy_d;
   logic          bit_done;
   logic          stop_sample;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State, counters and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         bit_idx_q      <= '0;
         shift_q        <= '0;
         par_en_q       <= 1'b0;
         par_odd_q      <= 1'b0;
         par_bit_q      <= 1'b0;
         data_out_q     <= '0;
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         frame_error_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bit_idx_q      <= bit_idx_d;
         shift_q        <= shift_d;
         par_en_q       <= par_en_d;
         par_odd_q      <= par_odd_d;
         par_bit_q      <= par_bit_d;
         data_out_q     <= data_out_d;
         data_valid_q   <= data_valid_d;
         parity_error_q <= parity_error_d;
         frame_error_q  <= frame_error_d;
         busy_q         <= busy_d;
      end
   end

   assign bit_done = (cnt_q == BIT_LAST);

   // Next-state logic: sample mid-bit, shift data in, deliver at the stop sample.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q + CW'(1);
      bit_idx_d      = bit_idx_q;
      shift_d        = shift_q;
      par_en_d       = par_en_q;
      par_odd_d      = par_odd_q;
      par_bit_d      = par_bit_q;
      data_out_d     = data_out_q;
      data_valid_d   = 1'b0;
      parity_error_d = parity_error_q;
      frame_error_d  = frame_error_q;
      stop_sample    = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            if (!rx_s_q) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  // Frame configuration is frozen for the rest of the frame.
                  state_d   = S_DATA;
                  par_en_d  = include_parity;
                  par_odd_d = parity_type;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (bit_done) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = '0;
                  state_d   = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_done) begin
               cnt_d     = '0;
               par_bit_d = rx_s_q;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               cnt_d          = '0;
               stop_sample    = 1'b1;
               data_out_d     = shift_q;
               data_valid_d   = 1'b1;
               parity_error_d = par_en_q & (par_bit_q ^ (^shift_q) ^ par_odd_q);
               frame_error_d  = ~rx_s_q;
               state_d        = rx_s_q ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            // A held-low line must return high before a new start is seen.
            cnt_d = '0;
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // busy follows the next state, but is held through the stop-sample edge
      // so it drops one cycle after data_valid on a good frame.
      busy_d = (state_d != S_IDLE) | stop_sample;
   end

   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign parity_error = parity_error_q;
   assign frame_error  = frame_error_q;
   assign busy         = busy_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive front end for the Fibonacci execution datapath. Oversamples the asynchronous `rx` line, frames 8-bit UART characters (start, 8 data bits LSB-first, optional parity, one stop bit), and presents each byte with a one-cycle valid strobe plus parity and framing status. Sits directly upstream of the execution stage's `Rx` consumer and shares its `include_parity` and `parity_type` configuration inputs.

## Interface
- `CLKS_PER_BIT`, 434, clocks per bit period (50 MHz / 115200); must be even and at least 4
- `clk`  in  1  system clock, rising-edge active
- `rst_n`  in  1  reset, asynchronous and active-low
- `rx`  in  1  asynchronous serial line, idle high
- `include_parity`  in  1  1 = a parity bit follows the data bits
- `parity_type`  in  1  0 = even, 1 = odd
- `data_out`  out  8  last received byte
- `data_valid`  out  1  one-cycle pulse when `data_out` and the flags update
- `parity_error`  out  1  parity mismatch on the last frame
- `frame_error`  out  1  stop bit sampled low on the last frame
- `busy`  out  1  high in any state other than IDLE

## Operation
- **Synchronizer:** 2-flop synchronizer on `rx`, both flops reset to 1. The FSM sees only the synchronized `rx_s`.
- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: `rx_s == 0` -> START, clear the cycle counter.
  - START: at count `HALF-1` (`HALF = CLKS_PER_BIT/2`), sample `rx_s`.
    - Sample 0: go to DATA. Latch `include_parity` and `parity_type` into frame registers; later changes during the frame are ignored.
    - Sample 1: glitch; return to IDLE with no output change.
  - DATA: sample every `CLKS_PER_BIT` cycles and shift into the shift register LSB-first. After the 8th bit go to PARITY if latched parity is on, else go to STOP.
  - PARITY: sample one bit. Expected bit = XOR of the 8 data bits, XOR latched `parity_type`.
  - STOP: sample one bit. In the same clock edge, load `data_out` and both error flags and pulse `data_valid`.
    - Stop = 1: go to IDLE.
    - Stop = 0: assert `frame_error` and go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. A held-low line never re-triggers reception.
- **Output updates:** the byte is delivered even when errors are flagged. `data_out`, `parity_error` and `frame_error` hold until the next STOP sample.
- **Parity disabled:** `parity_error` is forced to 0 on that frame.
- **Counter:** one counter, `$clog2(CLKS_PER_BIT)` bits, plus a 3-bit bit index. Counters do not wrap across states; they are cleared on every state transition.
- **Reset (asynchronous):** returns the FSM to IDLE at any point, including mid-frame. A partial frame is discarded and produces no `data_valid`.

## Timing
- **Reset values:** `data_out=8'h00`, `data_valid=0`, `parity_error=0`, `frame_error=0`, `busy=0`, synchronizer flops = 1, shift register = 0.
- **Start detection:** let edge N be the first clock edge at which the first synchronizer flop captures 0. The FSM enters START at edge N+2, which is the same edge `busy` rises.
- **Sample points:** the start mid-sample is at edge N+2+HALF. Data bit k (k = 0..7) is sampled at N+2+HALF+(k+1)·CLKS_PER_BIT.
- **Output edge:** let P = latched parity enable (0/1). The stop sample and the `data_valid` high edge are both at N+2+HALF+(9+P)·CLKS_PER_BIT. `data_valid` is low again one cycle later.
- **`busy`:** falls at the edge after the stop sample on a good frame. On a framing error it stays high through BREAK.
- **Back-to-back frames:** a start edge arriving in the cycle IDLE is re-entered is accepted. No dead time is required beyond the stop bit.
- **Throughput:** maximum one byte per (10+P)·CLKS_PER_BIT cycles.

## Test plan
Bench uses `CLKS_PER_BIT=16`; the line driver holds each bit for exactly 16 cycles.
- **No parity, 8'hA5:** `data_out=8'hA5`, single-cycle `data_valid` at N+2+8+144 = N+154, both flags 0, `busy` low one cycle later.
- **Even parity, 8'h0D, parity bit 1:** `data_out=8'h0D`, `parity_error=0`. Same byte with parity bit 0: `parity_error=1`, byte still delivered.
- **Odd parity, 8'h00, parity bit 1:** no error. Then toggle `parity_type` mid-frame: no effect on the frame in progress.
- **Stop bit driven 0 on 8'h3C:** `frame_error=1`, `data_out=8'h3C`. Line held low 100 cycles: no second `data_valid`, `busy` high. Line released: `busy` drops, and the next frame 8'h11 is received cleanly with `frame_error` cleared.
- **4-cycle low glitch on idle line:** FSM returns to IDLE after the start mid-sample, no `data_valid`, outputs unchanged.
- **`rst_n` pulsed low during data bit 3 of 8'hFF:** all outputs go to reset values immediately. The partial frame is never delivered, and a following 8'h42 frame is received correctly.
